// File: rtl/pll_pkg.sv
// pll_pkg: shared FSM state encoding and period width for the PLL output generators.
package pll_pkg;
    localparam int PERIOD_W = 32;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer for an asynchronous input plus a registered rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic RST_N,
    input  logic din,
    output logic rise
);
    logic s1, s2, s3;
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            {s1, s2, s3, rise} <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/period_detect.sv
// period_detect: measures the ref_in period in clk cycles and flags it stable after
// STABLE_COUNT consecutive in-tolerance periods; drops on change, timeout or power-down.
module period_detect
    import pll_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int SAMPLE_NS    = 1,
    parameter int STABLE_COUNT = 4,
    parameter int TOLERANCE    = 1,
    parameter int TIMEOUT      = 65535
) (
    input  logic                clk,
    input  logic                RST_N,
    input  logic                PWRDWN,
    input  logic                ref_in,
    output logic [PERIOD_W-1:0] ref_period,
    output logic                period_stable,
    output logic                lost
);
    localparam int M_W = $clog2(STABLE_COUNT + 1);
    logic                ref_edge;
    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt, last, diff;
    logic [M_W-1:0]      match;
    logic                hit, lock_now, timeout;
    logic [PERIOD_W-1:0] period_ns;
    edge_sync u_sync (
        .clk  (clk),
        .RST_N(RST_N),
        .din  (ref_in),
        .rise (ref_edge)
    );
    always_comb begin
        diff      = cnt >= last ? cnt - last : last - cnt;
        hit       = diff <= CNT_W'(TOLERANCE);
        lock_now  = (match + M_W'(1)) == M_W'(STABLE_COUNT);
        timeout   = state != ST_IDLE && !ref_edge && cnt == CNT_W'(TIMEOUT);
        period_ns = PERIOD_W'(cnt * CNT_W'(SAMPLE_NS));
    end
    // cnt holds the cycles since the previous edge; it is read before being restarted
    always_ff @(posedge clk) begin
        if (!RST_N || PWRDWN) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            last          <= '0;
            match         <= '0;
            ref_period    <= '0;
            period_stable <= 1'b0;
            lost          <= 1'b0;
        end else begin
            lost <= timeout;
            cnt  <= ref_edge ? CNT_W'(1) : cnt == CNT_W'(TIMEOUT) ? cnt : cnt + CNT_W'(1);
            if (timeout) begin
                state         <= ST_IDLE;
                period_stable <= 1'b0;
                ref_period    <= '0;
            end else if (ref_edge) begin
                if (state != ST_IDLE) last <= cnt;
                case (state)
                    ST_IDLE: state <= ST_FIRST;
                    ST_FIRST: begin
                        state <= ST_TRACK;
                        match <= '0;
                    end
                    ST_TRACK: begin
                        match <= hit ? match + M_W'(1) : '0;
                        if (hit && lock_now) begin
                            state         <= ST_LOCKED;
                            ref_period    <= period_ns;
                            period_stable <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (hit) begin
                            ref_period <= period_ns;
                        end else begin
                            state         <= ST_TRACK;
                            period_stable <= 1'b0;
                            match         <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_period_detect.sv
// tb_period_detect: directed ref_in periods; expected output changes are queued by the
// stimulus and checked by a monitor whenever the DUT outputs change.
`timescale 1ns/1ps
module tb_period_detect;
    typedef struct {
        int cyc;
        int st;
        int rp;
        int lost;
    } exp_t;
    logic        clk = 1'b0;
    logic        RST_N = 1'b0;
    logic        PWRDWN = 1'b0;
    logic        ref_in = 1'b0;
    logic [31:0] ref_period;
    logic        period_stable;
    logic        lost;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_n = 0;
    logic        fin = 1'b0;
    logic        fin_done = 1'b0;
    logic [33:0] cur;
    logic [33:0] prev = '0;
    logic [33:0] want;
    exp_t        e;
    exp_t        q[$];
    int tp[25] = '{10,10,10,10,10,10,11,10,9,13,13,13,13,13,10,10,10,10,10,20,20,20,20,20,20};
    int tc[25] = '{0,0,0,0,0,1,0,1,1,1,1,0,0,0,1,1,0,0,0,1,1,0,0,0,1};
    int ts[25] = '{0,0,0,0,0,1,0,1,1,1,0,0,0,0,1,0,0,0,0,1,0,0,0,0,1};
    int tr[25] = '{0,0,0,0,0,10,0,11,10,9,9,0,0,0,13,13,0,0,0,10,10,0,0,0,20};

    period_detect #(.TIMEOUT(100)) dut (
        .clk          (clk),
        .RST_N        (RST_N),
        .PWRDWN       (PWRDWN),
        .ref_in       (ref_in),
        .ref_period   (ref_period),
        .period_stable(period_stable),
        .lost         (lost)
    );

    always #0.5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A rise sampled at posedge n is seen by the FSM at posedge n+3
    task automatic pulse(input int p, input int c, input int s, input int r);
        ref_in = 1'b1;
        last_n = cyc + 1;
        if (c != 0) q.push_back('{last_n + 3, s, r, 0});
        repeat (p / 2) @(negedge clk);
        ref_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic relock();
        for (int i = 0; i < 6; i++) pulse(10, i == 5 ? 1 : 0, 1, 10);
    endtask

    always @(negedge clk) begin
        cur = {period_stable, ref_period, lost};
        if (cyc <= 3) begin
            checks++;
            if (cur !== 34'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got st=%b rp=%0d lost=%b expected all 0", cyc, cur[33], cur[32:1], cur[0]);
            end
        end else if (cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got st=%b rp=%0d lost=%b expected no change", cyc, cur[33], cur[32:1], cur[0]);
            end else begin
                e = q.pop_front();
                want = {e.st[0], e.rp[31:0], e.lost[0]};
                if (cyc != e.cyc || cur !== want) begin
                    errors++;
                    $display("FAIL out_change got cyc=%0d st=%b rp=%0d lost=%b expected cyc=%0d st=%b rp=%0d lost=%b",
                             cyc, cur[33], cur[32:1], cur[0], e.cyc, want[33], want[32:1], want[0]);
                end
            end
            prev = cur;
        end
        if (fin && !fin_done) begin
            fin_done = 1'b1;
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL pending_changes got %0d outstanding expected 0 (next cyc=%0d)", q.size(), q[0].cyc);
            end
        end
    end

    initial begin
        repeat (3) begin
            @(negedge clk);
            ref_in = ~ref_in;
        end
        RST_N  = 1'b1;
        ref_in = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 25; i++) pulse(tp[i], tc[i], ts[i], tr[i]);
        q.push_back('{last_n + 103, 0, 0, 1});
        q.push_back('{last_n + 104, 0, 0, 0});
        repeat (100) @(negedge clk);
        relock();
        PWRDWN = 1'b1;
        q.push_back('{cyc + 1, 0, 0, 0});
        @(negedge clk);
        PWRDWN = 1'b0;
        repeat (3) @(negedge clk);
        relock();
        RST_N = 1'b0;
        q.push_back('{cyc + 1, 0, 0, 0});
        @(negedge clk);
        RST_N = 1'b1;
        repeat (3) @(negedge clk);
        relock();
        repeat (30) @(negedge clk);
        fin = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog cyc=%0d expected run to end before 20000 cycles", cyc);
        $fatal(1);
    end
endmodule
